// File: rtl/concat_unpacker.sv
// concat_unpacker: serial receiver and field splitter for 8-bit words packed
// as {a[2:0], c, c, b[2:0]}. It collects one bit per accepted cycle, then
// splits the word into a/b/c, flags disagreement between the two c copies,
// and hands the result off through a valid/ready output handshake.
module concat_unpacker #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [2:0]       a,
  output logic             c,
  output logic [2:0]       b,
  output logic             rep_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic {
    SHIFT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] sreg;
  logic [7:0] word_next;

  // Word as it stands once the current bit is included; on the 8th accepted
  // bit this is the complete word, so the fields decode from it directly.
  assign word_next = MSB_FIRST ? {sreg[6:0], sin} : {sin, sreg[7:1]};

  // Handshake outputs depend only on the state register, so there is no
  // combinational path from sin/sin_valid to any output.
  assign sin_ready = (state == SHIFT);
  assign out_valid = (state == HOLD);

  // Receive FSM: shift bits in, register the decoded fields, hold for handoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; blocking here would create ordering races.
      state     <= SHIFT;
      bit_cnt   <= 3'd0;
      sreg      <= 8'd0;
      a         <= 3'd0;
      b         <= 3'd0;
      c         <= 1'b0;
      rep_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        SHIFT: begin
          if (sin_valid) begin
            sreg <= word_next;
            if (bit_cnt == 3'd7) begin
              a       <= word_next[7:5];
              c       <= word_next[4];
              b       <= word_next[2:0];
              rep_err <= word_next[4] ^ word_next[3];
              bit_cnt <= 3'd0;
              state   <= HOLD;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        HOLD: begin
          // Input bits are ignored here; sin_ready is low while holding.
          if (out_ready) begin
            frame_cnt <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            state     <= SHIFT;
          end
        end
        default: state <= SHIFT;
      endcase
    end
  end

endmodule
